// File: rtl/ah_snoop_fifo_pkg.sv
// Shared types, default sizes and the popcount helper for the snoopable FIFO.
package ah_snoop_fifo_pkg;

  localparam int DEF_DATA_W = 110;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_KEY_W  = 32;
  localparam int DEF_AW     = $clog2(DEF_DEPTH);
  localparam int POP_MAX    = 1024;

  // Pointer type for the default depth: one extra MSB separates full from empty.
  typedef logic [DEF_AW:0] ptr_t;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/ah_snoop_fifo_if.sv
// Bus bundle for ah_snoop_fifo: write, read and snoop channels plus occupancy.
// The sinv signal exists only when AH_SNOOP_INV_EN is defined.
interface ah_snoop_fifo_if
  import ah_snoop_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int KEY_W  = DEF_KEY_W
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;
  logic [KEY_W-1:0]  sdata;
  logic              svalid;
`ifdef AH_SNOOP_INV_EN
  logic              sinv;
`endif
  logic              smatch;
  logic [AW:0]       scount;
  logic [AW:0]       count;

  modport slave (
`ifdef AH_SNOOP_INV_EN
    input  sinv,
`endif
    input  wdata, wvalid, rready, sdata, svalid,
    output wready, rdata, rvalid, smatch, scount, count
  );

  modport master (
`ifdef AH_SNOOP_INV_EN
    output sinv,
`endif
    output wdata, wvalid, rready, sdata, svalid,
    input  wready, rdata, rvalid, smatch, scount, count
  );

endinterface

// File: rtl/ah_snoop_cmp.sv
// Combinational key comparator: one hit per live entry whose key equals the snoop key.
module ah_snoop_cmp
  import ah_snoop_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic [KEY_W-1:0]       key_i [DEPTH],
  input  logic [DEPTH-1:0]       occ_i,
  input  logic [KEY_W-1:0]       sdata_i,
  output logic [DEPTH-1:0]       hit_o,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < DEPTH; i++) hit_o[i] = occ_i[i] && (key_i[i] == sdata_i);
  end

  assign cnt_o = CW'(popcount(POP_MAX'(hit_o)));

endmodule

// File: rtl/ah_snoop_fifo.sv
// First-word-fall-through FIFO with a registered content-addressable snoop port.
// Define AH_SNOOP_INV_EN to add snoop invalidation (sinv) with auto-drop of killed heads.
module ah_snoop_fifo
  import ah_snoop_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int KEY_W  = DEF_KEY_W
) (
  input logic            clk,
  input logic            rstn,
  ah_snoop_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [KEY_W-1:0]  key   [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  occ_q, occ_d;
  logic              smatch_q, smatch_d;
  logic [AW:0]       scount_q, scount_d;
  logic [DEPTH-1:0]  live, hit;
  logic [AW:0]       hit_cnt;
  logic [AW-1:0]     widx, ridx;
  logic              empty, full, push, adv, head_kill, rvalid;

  assign widx  = wr_ptr_q[AW-1:0];
  assign ridx  = rd_ptr_q[AW-1:0];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (widx == ridx);
  assign push  = bus.wvalid && !full;

`ifdef AH_SNOOP_INV_EN
  logic [DEPTH-1:0] kill_q, kill_d;

  assign head_kill = !empty && kill_q[ridx];
  assign live      = occ_q & ~kill_q;

  always_comb begin
    kill_d = kill_q;
    if (bus.svalid && bus.sinv) kill_d = kill_d | hit;
    if (adv)  kill_d[ridx] = 1'b0;
    if (push) kill_d[widx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) kill_q <= '0;
    else       kill_q <= kill_d;
  end
`else
  assign head_kill = 1'b0;
  assign live      = occ_q;
`endif

  // A killed head is hidden from the consumer and dropped without a handshake.
  assign rvalid = !empty && !head_kill;
  assign adv    = (rvalid && bus.rready) || head_kill;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) key[i] = mem_q[i][KEY_W-1:0];
  end

  ah_snoop_cmp #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_cmp (
    .key_i   (key),
    .occ_i   (live),
    .sdata_i (bus.sdata),
    .hit_o   (hit),
    .cnt_o   (hit_cnt)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, adv};
    occ_d    = occ_q;
    if (adv)  occ_d[ridx] = 1'b0;
    if (push) occ_d[widx] = 1'b1;
    smatch_d = bus.svalid && (|hit);
    scount_d = bus.svalid ? hit_cnt : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      smatch_q <= 1'b0;
      scount_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      smatch_q <= smatch_d;
      scount_q <= scount_d;
    end
  end

  // Storage is cleared on reset so the fall-through head is never X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[widx] <= bus.wdata;
    end
  end

  assign bus.wready = !full;
  assign bus.rvalid = rvalid;
  assign bus.rdata  = mem_q[ridx];
  assign bus.smatch = smatch_q;
  assign bus.scount = scount_q;
  assign bus.count  = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_ah_snoop_fifo.sv
// Self-checking bench for ah_snoop_fifo: queue-based reference model plus directed literal checks.
module tb_ah_snoop_fifo;
  localparam int DATA_W = 110;
  localparam int DEPTH  = 32;
  localparam int KEY_W  = 32;
`ifdef AH_SNOOP_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    bit                k;
  } ent_t;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;
  bit   chk_en;
  ent_t mq[$];
  bit   exp_smatch;
  int   exp_scount;

  ah_snoop_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .KEY_W(KEY_W)) bus ();

  ah_snoop_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .KEY_W(KEY_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data(input logic [KEY_W-1:0] key);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    t[KEY_W-1:0] = key;
    return t[DATA_W-1:0];
  endfunction

  // One clock of stimulus; the model advances from the contents as they stood before the edge.
  task automatic do_cycle(input bit wv, input logic [DATA_W-1:0] wd, input bit rr,
                          input bit sv, input logic [KEY_W-1:0] sd, input bit si);
    int hits;
    bit do_push, do_pop, do_drop;
    bus.wvalid = wv;
    bus.wdata  = wd;
    bus.rready = rr;
    bus.svalid = sv;
    bus.sdata  = sd;
`ifdef AH_SNOOP_INV_EN
    bus.sinv   = si;
`endif
    hits = 0;
    foreach (mq[j]) if (!mq[j].k && mq[j].d[KEY_W-1:0] == sd) hits++;
    do_push = wv && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && !mq[0].k && rr;
    do_drop = (mq.size() > 0) && mq[0].k;
    @(posedge clk);
    if (INV_EN && sv && si)
      foreach (mq[j]) if (!mq[j].k && mq[j].d[KEY_W-1:0] == sd) mq[j].k = 1'b1;
    if (do_pop || do_drop) void'(mq.pop_front());
    if (do_push) mq.push_back('{d: wd, k: 1'b0});
    exp_smatch = sv && (hits > 0);
    exp_scount = sv ? hits : 0;
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",  128'(bus.count),  128'(mq.size()));
      chk("wready", 128'(bus.wready), 128'(mq.size() < DEPTH));
      chk("rvalid", 128'(bus.rvalid), 128'((mq.size() > 0) && !mq[0].k));
      if ((mq.size() > 0) && !mq[0].k) chk("rdata", 128'(bus.rdata), 128'(mq[0].d));
      chk("smatch", 128'(bus.smatch), 128'(exp_smatch));
      chk("scount", 128'(bus.scount), 128'(exp_scount));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; chk_en = 1'b0;
    exp_smatch = 1'b0; exp_scount = 0;
    rstn = 1'b0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.rready = 1'b0;
    bus.svalid = 1'b0; bus.sdata = '0;
`ifdef AH_SNOOP_INV_EN
    bus.sinv = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    chk("rst_count",  128'(bus.count),  128'd0);
    chk("rst_wready", 128'(bus.wready), 128'd1);
    chk("rst_rvalid", 128'(bus.rvalid), 128'd0);
    chk("rst_smatch", 128'(bus.smatch), 128'd0);
    chk("rst_scount", 128'(bus.scount), 128'd0);
    chk("rst_rdata",  128'(bus.rdata),  128'd0);
    chk_en = 1'b1;

    // Fill to full with 1..32
    for (int i = 1; i <= DEPTH; i++) do_cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, '0, 1'b0);
    chk("full_count",  128'(bus.count),  128'd32);
    chk("full_wready", 128'(bus.wready), 128'd0);
    chk("full_head",   128'(bus.rdata),  128'd1);

    // Pop and push together while full: pop wins, push is refused
    do_cycle(1'b1, DATA_W'(99), 1'b1, 1'b0, '0, 1'b0);
    chk("fullpp_count",  128'(bus.count),  128'd31);
    chk("fullpp_wready", 128'(bus.wready), 128'd1);
    for (int i = 2; i <= DEPTH; i++) begin
      chk("order", 128'(bus.rdata), 128'(i));
      do_cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    chk("drain_rvalid", 128'(bus.rvalid), 128'd0);
    chk("drain_count",  128'(bus.count),  128'd0);

    // Snoop counting; a stale key 5 from the fill still sits in unoccupied storage
    do_cycle(1'b1, rnd_data(32'd5), 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b1, rnd_data(32'd7), 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b1, rnd_data(32'd5), 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b1, 32'd5, 1'b0);
    chk("snoop5_match", 128'(bus.smatch), 128'd1);
    chk("snoop5_count", 128'(bus.scount), 128'd2);
    do_cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b1, 32'd5, 1'b0);
    chk("snoop5_after_pop", 128'(bus.scount), 128'd1);
    idle();
    chk("snoop_idle_zero", 128'(bus.smatch), 128'd0);
    for (int n = 0; n < 4; n++) do_cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Randomized traffic, long enough for several pointer wraps
    for (int n = 0; n < 400; n++)
      do_cycle($urandom_range(0, 99) < 60, rnd_data(KEY_W'($urandom_range(0, 7))),
               $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
               KEY_W'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
    for (int n = 0; n < 3 * DEPTH && mq.size() > 0; n++)
      do_cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("rand_drain_count", 128'(bus.count), 128'd0);
    do_cycle(1'b1, rnd_data(32'd100), 1'b0, 1'b1, 32'd3, 1'b0);
    chk("popped_key_match", 128'(bus.smatch), 128'd0);
    chk("popped_key_count", 128'(bus.scount), 128'd0);
    do_cycle(1'b0, '0, 1'b1, 1'b1, 32'd100, 1'b0);
    chk("new_key_match", 128'(bus.smatch), 128'd1);

`ifdef AH_SNOOP_INV_EN
    begin
      int nreads;
      do_cycle(1'b1, rnd_data(32'd9), 1'b0, 1'b0, '0, 1'b0);
      do_cycle(1'b1, rnd_data(32'd3), 1'b0, 1'b0, '0, 1'b0);
      do_cycle(1'b1, rnd_data(32'd9), 1'b0, 1'b0, '0, 1'b0);
      do_cycle(1'b0, '0, 1'b0, 1'b1, 32'd9, 1'b1);
      chk("inv_scount",      128'(bus.scount), 128'd2);
      chk("inv_head_hidden", 128'(bus.rvalid), 128'd0);
      chk("inv_count",       128'(bus.count),  128'd3);
      nreads = 0;
      for (int n = 0; n < 6; n++) begin
        if (bus.rvalid) begin
          nreads++;
          chk("inv_read_key", 128'(bus.rdata[KEY_W-1:0]), 128'd3);
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      end
      chk("inv_nreads", 128'(nreads), 128'd1);
      chk("inv_end_count", 128'(bus.count), 128'd0);
      do_cycle(1'b0, '0, 1'b0, 1'b1, 32'd9, 1'b0);
      chk("inv_no_rehit", 128'(bus.smatch), 128'd0);
    end
`endif

    // Asynchronous reset mid-stream with 10 entries held
    for (int i = 0; i < 10; i++) do_cycle(1'b1, rnd_data(KEY_W'(40 + i)), 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b1, 32'd42, 1'b0);
    chk("pre_rst_match", 128'(bus.smatch), 128'd1);
    chk("pre_rst_count", 128'(bus.count),  128'd10);
    bus.svalid = 1'b0; bus.wvalid = 1'b0; bus.rready = 1'b0;
    #2;
    rstn = 1'b0;
    mq.delete();
    exp_smatch = 1'b0;
    exp_scount = 0;
    #1;
    chk("async_rst_count",  128'(bus.count),  128'd0);
    chk("async_rst_rvalid", 128'(bus.rvalid), 128'd0);
    chk("async_rst_smatch", 128'(bus.smatch), 128'd0);
    chk("async_rst_wready", 128'(bus.wready), 128'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    do_cycle(1'b0, '0, 1'b0, 1'b1, 32'd42, 1'b0);
    chk("post_rst_snoop", 128'(bus.smatch), 128'd0);
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
